// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, WAIT_CYC wait states, byte-lane stores and extended loads.
// Optional macro DM_ALIGN_CHECK_EN: illegal lane patterns report rsp_err and are suppressed.
module dm_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic        req_ue,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] wait_cnt;
  logic [31:0] mem [DEPTH];

  logic              cap_we;
  logic              cap_ue;
  logic [3:0]        cap_be;
  logic [1:0]        cap_off;
  logic [ADDR_W-1:0] cap_idx;
  logic [31:0]       cap_wdata;

  logic        accept;
  logic        legal;
  logic [2:0]  lanes;
  logic [31:0] rd_word;
  logic [31:0] load_val;
  logic [31:0] load_res;
  logic [31:0] wr_lanes;
  logic [3:0]  wr_mask;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  function automatic logic [2:0] lane_count(input logic [3:0] be);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, be[i]};
    return n;
  endfunction

  // Legal means a naturally sized (1/2/4 byte) run of lanes that starts at the address offset.
  function automatic logic is_legal(input logic [3:0] be, input logic [1:0] off);
    logic [6:0] span;
    case (lane_count(be))
      3'd1:    span = 7'b0000001 << off;
      3'd2:    span = 7'b0000011 << off;
      3'd4:    span = 7'b0001111 << off;
      default: span = 7'h7F;
    endcase
    return {3'b000, be} == span;
  endfunction

  // Enabled lanes, ascending, packed into the low bytes of the result.
  function automatic logic [31:0] gather_lanes(input logic [31:0] word, input logic [3:0] be);
    logic [31:0] res;
    logic [1:0]  pos;
    res = '0;
    pos = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*pos +: 8] = word[8*i +: 8];
        pos = pos + 2'd1;
      end
    end
    return res;
  endfunction

  // Inverse of gather: low store bytes spread onto the enabled lanes in ascending order.
  function automatic logic [31:0] scatter_lanes(input logic [31:0] data, input logic [3:0] be);
    logic [31:0] res;
    logic [1:0]  pos;
    res = '0;
    pos = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = data[8*pos +: 8];
        pos = pos + 2'd1;
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] n,
                                              input logic sign_ext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    if (sign_ext && n == 3'd1) return 32'(b);
    if (sign_ext && n == 3'd2) return 32'(h);
    return raw;
  endfunction

  assign accept = req_valid && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (WAIT_CYC > 0) ? S_WAIT : S_EXEC;
      end
      S_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)                 wait_cnt <= '0;
    else if (accept)          wait_cnt <= 4'd1;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 4'd1;
    else                      wait_cnt <= '0;
  end

  // Request capture: inputs are free to change once accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_ue    <= req_ue;
      cap_be    <= req_be;
      cap_off   <= req_addr[1:0];
      cap_idx   <= req_addr[ADDR_W+1:2];
      cap_wdata <= req_wdata;
    end
  end

  // Execute: decode the captured request against the current word.
  always_comb begin
    rd_word  = mem[cap_idx];
    lanes    = lane_count(cap_be);
    legal    = is_legal(cap_be, cap_off);
    load_val = extend_load(gather_lanes(rd_word, cap_be), lanes, legal && !cap_ue);
    wr_lanes = scatter_lanes(cap_wdata, cap_be);
`ifdef DM_ALIGN_CHECK_EN
    wr_mask  = legal ? cap_be : 4'b0000;
    load_res = legal ? load_val : 32'd0;
`else
    wr_mask  = cap_be;
    load_res = load_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst && state == S_EXEC && cap_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[cap_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                 rsp_rdata <= '0;
    else if (state == S_EXEC) rsp_rdata <= cap_we ? 32'd0 : load_res;
  end

`ifdef DM_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst)                 err_q <= 1'b0;
    else if (state == S_EXEC) err_q <= !legal && (cap_be != 4'b0000);
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: spec-level model with per-cycle compare, directed literal checks,
// and a second WAIT_CYC=0 instance for back-to-back throughput.
module tb_dm_responder;

  localparam int ADDR_W = 10;
  localparam int WAITN  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_we, req_ue;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        rst0, v0, we0, ue0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0;
  logic        ready0, valid0, err0;
  logic [31:0] rdata0;

  dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAITN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_ue(req_ue), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(ready0), .req_we(we0),
    .req_be(be0), .req_ue(ue0), .req_addr(addr0), .req_wdata(wdata0),
    .rsp_valid(valid0), .rsp_rdata(rdata0), .rsp_err(err0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [int];

  function automatic int ones(input logic [3:0] be);
    int n = 0;
    for (int i = 0; i < 4; i++) if (be[i]) n++;
    return n;
  endfunction

  function automatic bit m_legal(input logic [1:0] off, input logic [3:0] be);
    int n = ones(be);
    int o = int'(off);
    return (n == 1 || n == 2 || n == 4) && (o + n <= 4) && (int'(be) == (((1 << n) - 1) << o));
  endfunction

  function automatic bit m_err(input logic [1:0] off, input logic [3:0] be);
`ifdef DM_ALIGN_CHECK_EN
    return (be != 4'b0000) && !m_legal(off, be);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] off,
                                         input logic [3:0] be, input logic ue);
    int n = ones(be);
    int o = int'(off);
    int k = 0;
    logic [31:0] v, mask;
    if (be == 4'b0000) return 32'd0;
    if (m_legal(off, be)) begin
      v = word >> (8 * o);
      if (n < 4) begin
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!ue && v[8*n-1]) v = v | ~mask;
      end
      return v;
    end
`ifdef DM_ALIGN_CHECK_EN
    return 32'd0;
`else
    v = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        v = v | (32'(word[8*i +: 8]) << (8 * k));
        k++;
      end
    end
    return v;
`endif
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [1:0] off,
                                          input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w = old;
    int n = ones(be);
    int o = int'(off);
    int k = 0;
    if (m_legal(off, be)) begin
      for (int j = 0; j < n; j++) w[8*(o+j) +: 8] = wd[8*j +: 8];
      return w;
    end
`ifndef DM_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        w[8*i +: 8] = wd[8*k +: 8];
        k++;
      end
    end
`endif
    return w;
  endfunction

  bit          armed = 1'b0, busy = 1'b0;
  int          since = 0;
  logic [31:0] last_rd = 32'd0, exp_rd = 32'd0;
  logic        last_err = 1'b0, exp_err = 1'b0;
  logic        m_we;
  logic [1:0]  m_off;
  logic [3:0]  m_be;
  logic [31:0] m_wd;
  int          m_idx;

  // Compare the DUT against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("ready", 32'(req_ready), 32'(!busy));
      chk("valid", 32'(rsp_valid), 32'(busy && since == WAITN + 1));
      chk("rdata", rsp_rdata, last_rd);
      if (busy && since == WAITN + 1) chk("err", 32'(rsp_err), 32'(last_err));
    end
    if (!rst) begin
      armed   = 1'b1;
      busy    = 1'b0;
      last_rd = 32'd0;
      last_err = 1'b0;
    end else if (armed) begin
      if (busy) begin
        since++;
        if (since == WAITN + 1) begin
          if (m_we) mm[m_idx] = m_store(mm[m_idx], m_off, m_be, m_wd);
          last_rd  = exp_rd;
          last_err = exp_err;
        end else if (since == WAITN + 2) begin
          busy = 1'b0;
        end
      end else if (req_valid) begin
        busy  = 1'b1;
        since = 0;
        m_we  = req_we;
        m_off = req_addr[1:0];
        m_be  = req_be;
        m_wd  = req_wdata;
        m_idx = int'(req_addr[ADDR_W+1:2]);
        exp_err = m_err(m_off, m_be);
        exp_rd  = m_we ? 32'd0 : m_load(mm.exists(m_idx) ? mm[m_idx] : 32'hxxxxxxxx,
                                        m_off, m_be, req_ue);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input logic we, input logic [3:0] be, input logic ue,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_be = be; req_ue = ue; req_addr = addr; req_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    chk("accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_be = 4'($urandom); req_ue = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    chk("response", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic st(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                    input logic exp_e);
    logic [31:0] rd;
    logic er;
    xact(1'b1, be, 1'b0, addr, wd, rd, er);
    chk("st_rdata", rd, 32'd0);
    chk("st_err", 32'(er), 32'(exp_e));
  endtask

  task automatic ld(input string name, input logic [31:0] addr, input logic [3:0] be,
                    input logic ue, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic er;
    xact(1'b0, be, ue, addr, 32'd0, rd, er);
    chk(name, rd, exp_d);
    chk({name, "_err"}, 32'(er), 32'(exp_e));
  endtask

  logic        b_we [6];
  logic [3:0]  b_be [6];
  logic        b_ue [6];
  logic [31:0] b_addr [6], b_wd [6], b_exp [6];

  task automatic b_apply(input int j);
    v0 = 1'b1; we0 = b_we[j]; be0 = b_be[j]; ue0 = b_ue[j]; addr0 = b_addr[j]; wdata0 = b_wd[j];
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    bit chk_en;
`ifdef DM_ALIGN_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_ue = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    rst0 = 1'b0; v0 = 1'b0; we0 = 1'b0; be0 = 4'h0; ue0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;

    @(posedge clk); @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst0_ready", 32'(ready0), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; rst0 = 1'b1;

    st(32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    ld("word", 32'h10, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0);

    st(32'h10, 4'hF, 32'h11223344, 1'b0);
    st(32'h13, 4'h8, 32'h000000A5, 1'b0);
    ld("byte_merge", 32'h10, 4'hF, 1'b0, 32'hA5223344, 1'b0);
    ld("byte_sext", 32'h13, 4'h8, 1'b0, 32'hFFFFFFA5, 1'b0);
    ld("byte_zext", 32'h13, 4'h8, 1'b1, 32'h000000A5, 1'b0);

    st(32'h10, 4'hF, 32'h80017FFF, 1'b0);
    ld("half_hi_sext", 32'h12, 4'hC, 1'b0, 32'hFFFF8001, 1'b0);
    ld("half_lo_sext", 32'h10, 4'h3, 1'b0, 32'h00007FFF, 1'b0);
    ld("half_hi_zext", 32'h12, 4'hC, 1'b1, 32'h00008001, 1'b0);
    ld("byte0_sext", 32'h10, 4'h1, 1'b0, 32'hFFFFFFFF, 1'b0);
    ld("word_ue", 32'h10, 4'hF, 1'b1, 32'h80017FFF, 1'b0);

    // Reset while the store sits in its wait states: no response, no commit.
    st(32'h20, 4'hF, 32'h01020304, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("abort_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    ld("abort_word", 32'h20, 4'hF, 1'b0, 32'h01020304, 1'b0);

    // Lane patterns that are not naturally aligned.
    st(32'h30, 4'hF, 32'h44332211, 1'b0);
    st(32'h31, 4'h5, 32'h0000BBAA, chk_en);
    ld("illegal_st_word", 32'h30, 4'hF, 1'b0, chk_en ? 32'h44332211 : 32'h44BB22AA, 1'b0);
    ld("illegal_ld_split", 32'h31, 4'h5, 1'b0, chk_en ? 32'h0 : (chk_en ? 32'h0 : 32'h0000BBAA), chk_en);
    ld("illegal_ld_three", 32'h30, 4'h7, 1'b0, chk_en ? 32'h0 : 32'h00BB22AA, chk_en);
    ld("illegal_ld_offset", 32'h30, 4'h2, 1'b0, chk_en ? 32'h0 : 32'h00000022, chk_en);
    ld("be_zero", 32'h30, 4'h0, 1'b0, 32'h0, 1'b0);
    st(32'h30, 4'h0, 32'hFFFFFFFF, 1'b0);
    ld("be_zero_store", 32'h30, 4'hF, 1'b0, chk_en ? 32'h44332211 : 32'h44BB22AA, 1'b0);

    // WAIT_CYC=0 instance, request held valid: one response every 3 cycles.
    b_we[0] = 1'b1; b_be[0] = 4'hF; b_ue[0] = 1'b0; b_addr[0] = 32'h14; b_wd[0] = 32'h89ABCDEF; b_exp[0] = 32'h0;
    b_we[1] = 1'b1; b_be[1] = 4'hC; b_ue[1] = 1'b0; b_addr[1] = 32'h16; b_wd[1] = 32'h00001234; b_exp[1] = 32'h0;
    b_we[2] = 1'b0; b_be[2] = 4'hF; b_ue[2] = 1'b0; b_addr[2] = 32'h14; b_wd[2] = 32'h0; b_exp[2] = 32'h1234CDEF;
    b_we[3] = 1'b0; b_be[3] = 4'h8; b_ue[3] = 1'b0; b_addr[3] = 32'h17; b_wd[3] = 32'h0; b_exp[3] = 32'h00000012;
    b_we[4] = 1'b0; b_be[4] = 4'hC; b_ue[4] = 1'b0; b_addr[4] = 32'h16; b_wd[4] = 32'h0; b_exp[4] = 32'h00001234;
    b_we[5] = 1'b0; b_be[5] = 4'h3; b_ue[5] = 1'b0; b_addr[5] = 32'h14; b_wd[5] = 32'h0; b_exp[5] = 32'hFFFFCDEF;
    @(posedge clk); #1;
    b_apply(0);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(ready0), 32'(k % 3 == 0));
      chk("b2b_valid", 32'(valid0), 32'(k % 3 == 2));
      if (k % 3 == 2) chk("b2b_rdata", rdata0, b_exp[k/3]);
      @(posedge clk); #1;
      if (k % 3 == 0) begin
        if (k / 3 + 1 < 6) b_apply(k / 3 + 1);
        else v0 = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
